scnn_decompression_ips: RTL and testbench
=========================================

Name: scnn_decompression_ips

Overview:
- Decoder counterpart of the activation compressor: rebuilds a dense activation slice from a compressed stream of (value, index) pairs.
- Used on the output/readback side of the 4-PE array, for example to re-expand compressed buffers for the next layer or for debug readout.
- Accepts one frame through a valid/ready stream, writes each value into a zero-cleared dense buffer, then presents the full dense slice with an output valid/ready handshake.

Parameters:
- NUM_ACTS, 64, number of dense activation slots.
- DATA_W, 16, activation width in bits.
- IDX_W, 8, compressed index width (matches the compressor's index format).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new frame; sampled only in IDLE, or in HOLD together with out_ready.
- in_valid  input  1  compressed beat valid.
- in_ready  output  1  high in LOAD state only.
- in_data  input  DATA_W  non-zero activation value.
- in_idx  input  IDX_W  dense position of in_data.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  dense frame available.
- out_ready  input  1  consumer accepts the dense frame.
- dense_out  output  NUM_ACTS*DATA_W  packed [NUM_ACTS-1:0][DATA_W-1:0] dense slice.
- nnz_count  output  IDX_W  count of in-range beats written this frame.
- err  output  1  sticky per frame: an out-of-range index (or an ordering violation, see Optional Feature) occurred.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0, out_valid=0.
  - All dense_out entries=0; nnz_count=0, err=0.
- FSM states: IDLE, LOAD, HOLD.
- in_ready and out_valid are decoded directly from the registered state: in_ready=(state==LOAD), out_valid=(state==HOLD).
- IDLE:
  - On start=1: next cycle all buffer entries=0, nnz_count=0, err=0, state=LOAD.
  - in_valid is ignored.
- LOAD:
  - A beat is accepted when in_valid && in_ready.
  - If in_idx < NUM_ACTS: buffer[in_idx] <= in_data and nnz_count increments (saturates at 2^IDX_W-1).
  - If in_idx >= NUM_ACTS: the beat is dropped and err <= 1.
  - Duplicate index: the last write wins, and nnz_count still increments.
  - in_data=0 is written as-is and counted.
  - Accepted beat with in_last=1: state=HOLD next cycle. Latency is last beat in cycle N -> out_valid=1 in cycle N+1.
  - start is ignored in LOAD.
  - Every frame carries at least one beat. An all-zero slice is sent as a single beat {data=0, idx=0, last=1}.
- HOLD:
  - dense_out, nnz_count and err hold stable.
  - out_ready=1 and start=0: state=IDLE next cycle.
  - out_ready=1 and start=1: back-to-back frame. Buffer, nnz_count and err clear, and state=LOAD next cycle with no IDLE bubble.
  - out_ready=0: stay in HOLD indefinitely.
- dense_out is driven straight from the buffer register and changes only on an accepted write or on a frame clear.
- Reset asserted mid-LOAD or mid-HOLD aborts the frame immediately and returns to reset values; the partial frame is discarded.

Optional Feature:
- Macro SCNN_DECOMP_ORDER_CHK_EN.
- Defined:
  - A register holds the last accepted in-range index of the current frame.
  - Any accepted in-range beat whose in_idx is <= the previous index (indices not strictly ascending, as the compressor emits them) sets err=1.
  - The write still occurs.
  - The check resets on each frame clear.
- Not defined: no ordering check and no extra register; err reflects only out-of-range indices.

Test Plan:
- Basic frame: start, then beats (5,idx3),(7,idx10),(9,idx63,last) -> out_valid one cycle after the last beat; dense_out[3]=5, [10]=7, [63]=9, all other entries 0; nnz_count=3; err=0.
- Out of range: beats (4,idx2),(8,idx64),(6,idx70,last) -> only [2]=4; nnz_count=1; err=1.
- Backpressure: hold out_ready=0 for 10 cycles after HOLD -> dense_out stable and in_ready=0 throughout. Then out_ready=1 with start=1 -> next cycle state LOAD and dense_out all 0.
- Zero/duplicate: single beat (0,idx0,last) -> all entries 0, nnz_count=1. Then beats (3,idx5),(11,idx5,last) -> [5]=11, nnz_count=2.
- Reset mid-frame: rst_n low after 2 accepted beats -> outputs 0 asynchronously. After release, a start pulse plus one beat (1,idx1,last) yields dense_out[1]=1 only.
- Ordering (macro on): beats (2,idx9),(3,idx4,last) -> [9]=2, [4]=3, err=1. With the macro off, the same stimulus gives err=0.

Source files
------------

// File: rtl/scnn_decompression_ips_if.sv
// Stream-in / dense-out bundle for the activation decompressor.
// The master side produces compressed beats and consumes the dense slice.
interface scnn_decompression_ips_if #(
  parameter int unsigned NUM_ACTS = 64,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IDX_W    = 8
);
  logic                               start;
  logic                               in_valid;
  logic                               in_ready;
  logic [DATA_W-1:0]                  in_data;
  logic [IDX_W-1:0]                   in_idx;
  logic                               in_last;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_ACTS-1:0][DATA_W-1:0]    dense_out;
  logic [IDX_W-1:0]                   nnz_count;
  logic                               err;

  modport master (
    output start, in_valid, in_data, in_idx, in_last, out_ready,
    input  in_ready, out_valid, dense_out, nnz_count, err
  );

  modport slave (
    input  start, in_valid, in_data, in_idx, in_last, out_ready,
    output in_ready, out_valid, dense_out, nnz_count, err
  );
endinterface

// File: rtl/scnn_decompression_ips.sv
// Rebuilds a dense activation slice from a (value, index) stream into a zero-cleared buffer.
// Define SCNN_DECOMP_ORDER_CHK_EN to also flag non-ascending indices in err.
module scnn_decompression_ips #(
  parameter int unsigned NUM_ACTS = 64,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IDX_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  scnn_decompression_ips_if.slave   bus
);
  localparam int unsigned AddrW = (NUM_ACTS > 1) ? $clog2(NUM_ACTS) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e                           state_q, state_d;
  logic [NUM_ACTS-1:0][DATA_W-1:0]  buf_q, buf_d;
  logic [IDX_W-1:0]                 nnz_q, nnz_d;
  logic                             err_q, err_d;
  logic                             in_range;
  logic [AddrW-1:0]                 addr;

`ifdef SCNN_DECOMP_ORDER_CHK_EN
  logic [AddrW-1:0]                 prev_idx_q, prev_idx_d;
  logic                             prev_vld_q, prev_vld_d;
`endif

  // Widen before comparing so NUM_ACTS values beyond the index range still work.
  assign in_range = (32'(bus.in_idx) < NUM_ACTS);
  assign addr     = AddrW'(bus.in_idx);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    nnz_d   = nnz_q;
    err_d   = err_q;
`ifdef SCNN_DECOMP_ORDER_CHK_EN
    prev_idx_d = prev_idx_q;
    prev_vld_d = prev_vld_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          buf_d   = '0;
          nnz_d   = '0;
          err_d   = 1'b0;
`ifdef SCNN_DECOMP_ORDER_CHK_EN
          prev_vld_d = 1'b0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (in_range) begin
            buf_d[addr] = bus.in_data;
            if (nnz_q != '1) nnz_d = nnz_q + 1'b1;
`ifdef SCNN_DECOMP_ORDER_CHK_EN
            if (prev_vld_q && (addr <= prev_idx_q)) err_d = 1'b1;
            prev_idx_d = addr;
            prev_vld_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
          if (bus.in_last) state_d = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            // Back-to-back frame: clear and reload without passing through idle.
            buf_d   = '0;
            nnz_d   = '0;
            err_d   = 1'b0;
`ifdef SCNN_DECOMP_ORDER_CHK_EN
            prev_vld_d = 1'b0;
`endif
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      nnz_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      nnz_q   <= nnz_d;
      err_q   <= err_d;
    end
  end

`ifdef SCNN_DECOMP_ORDER_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_idx_q <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_idx_q <= prev_idx_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.out_valid = (state_q == StHold);
  assign bus.dense_out = buf_q;
  assign bus.nnz_count = nnz_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_scnn_decompression_ips.sv
// Frame-table bench for scnn_decompression_ips with an expected-result queue.
module tb_scnn_decompression_ips;
  localparam int unsigned NA = 64;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned VW = NA * DW;
`ifdef SCNN_DECOMP_ORDER_CHK_EN
  localparam logic Ord = 1'b1;
`else
  localparam logic Ord = 1'b0;
`endif

  typedef struct {
    int              n;
    logic [2:0][15:0] d;
    logic [2:0][7:0]  i;
    logic [7:0]       nnz;
    logic             err;
  } vec_t;

  typedef struct {
    logic [VW-1:0] dense;
    logic [IW-1:0] nnz;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[5];
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  scnn_decompression_ips_if #(.NUM_ACTS(NA), .DATA_W(DW), .IDX_W(IW)) bus ();

  scnn_decompression_ips #(.NUM_ACTS(NA), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] model(input int n, input logic [2:0][15:0] d,
                                          input logic [2:0][7:0] i);
    logic [NA-1:0][DW-1:0] m;
    m = '0;
    for (int b = 0; b < n; b++) begin
      if (int'(i[b]) < NA) m[i[b]] = d[b];
    end
    return m;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [7:0] i, input logic l);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_idx   = i;
    bus.in_last  = l;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.dense = model(v.n, v.d, v.i);
    e.nnz   = v.nnz;
    e.err   = v.err;
    for (int b = 0; b < v.n; b++) begin
      if (b == v.n - 1) sb.push_back(e);
      send_beat(v.d[b], v.i[b], (b == v.n - 1));
    end
  endtask

  // Called right after the last beat: out_valid must already be high one cycle later.
  task automatic check_out(input string nm);
    @(negedge clk);
    chk({nm, "_latency"}, VW'(bus.out_valid), VW'(1'b1));
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", nm);
    end else begin
      cur = sb.pop_front();
      chk({nm, "_dense"}, bus.dense_out, cur.dense);
      chk({nm, "_nnz"}, VW'(bus.nnz_count), VW'(cur.nnz));
      chk({nm, "_err"}, VW'(bus.err), VW'(cur.err));
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [VW-1:0] snap;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_idx = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;

    tbl[0] = '{n: 3, d: {16'd9, 16'd7, 16'd5},  i: {8'd63, 8'd10, 8'd3}, nnz: 8'd3, err: 1'b0};
    tbl[1] = '{n: 3, d: {16'd6, 16'd8, 16'd4},  i: {8'd70, 8'd64, 8'd2}, nnz: 8'd1, err: 1'b1};
    tbl[2] = '{n: 1, d: {16'd0, 16'd0, 16'd0},  i: {8'd0, 8'd0, 8'd0},   nnz: 8'd1, err: 1'b0};
    tbl[3] = '{n: 2, d: {16'd0, 16'd11, 16'd3}, i: {8'd0, 8'd5, 8'd5},   nnz: 8'd2, err: Ord};
    tbl[4] = '{n: 2, d: {16'd0, 16'd3, 16'd2},  i: {8'd0, 8'd4, 8'd9},   nnz: 8'd2, err: Ord};

    #12;
    chk("rst_in_ready", VW'(bus.in_ready), '0);
    chk("rst_out_valid", VW'(bus.out_valid), '0);
    chk("rst_dense", bus.dense_out, '0);
    chk("rst_nnz", VW'(bus.nnz_count), '0);
    chk("rst_err", VW'(bus.err), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid in idle must be ignored
    bus.in_valid = 1'b1; bus.in_data = 16'hbeef; bus.in_idx = 8'd1; bus.in_last = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("idle_ignore_dense", bus.dense_out, '0);
    chk("idle_ignore_ready", VW'(bus.in_ready), '0);

    for (int k = 0; k < 5; k++) begin
      do_start();
      send_frame(tbl[k]);
      check_out($sformatf("frame%0d", k));
      release_out();
      chk($sformatf("frame%0d_idle", k), VW'(bus.out_valid), '0);
    end

    // Backpressure: hold for 10 cycles, then back-to-back start.
    do_start();
    send_frame(tbl[0]);
    check_out("bp");
    snap = cur.dense;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_stable%0d", c), bus.dense_out, snap);
      chk($sformatf("bp_ready%0d", c), VW'({bus.in_ready, bus.out_valid}), VW'(2'b01));
    end
    bus.out_ready = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("b2b_load", VW'({bus.in_ready, bus.out_valid}), VW'(2'b10));
    chk("b2b_clear", bus.dense_out, '0);
    chk("b2b_nnz", VW'(bus.nnz_count), '0);
    send_frame(tbl[3]);
    check_out("b2b");
    release_out();

    // Reset mid-frame discards the partial frame.
    do_start();
    send_beat(16'd5, 8'd3, 1'b0);
    send_beat(16'd7, 8'd10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dense", bus.dense_out, '0);
    chk("midrst_nnz", VW'(bus.nnz_count), '0);
    chk("midrst_ready", VW'({bus.in_ready, bus.out_valid}), '0);
    @(negedge clk) rst_n = 1'b1;
    do_start();
    v = '{n: 1, d: {16'd0, 16'd0, 16'd1}, i: {8'd0, 8'd0, 8'd1}, nnz: 8'd1, err: 1'b0};
    send_frame(v);
    check_out("postrst");
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
